// File: rtl/prog_launcher_if.sv
// Host <-> launcher bundle: launch request, start-address table configuration,
// core control strobes and the status of the last run.
interface prog_launcher_if #(
    parameter int SEL_W = 2,
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             req;
    logic [SEL_W-1:0] prog_sel;
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_idx;
    logic [PC_W-1:0]  cfg_addr;
    logic             abort;
    logic             halt;
    logic             core_reset;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic             run;
    logic             busy;
    logic             ack;
    logic             timeout;
    logic             aborted;
    logic [CNT_W-1:0] cycles;

    // Host side: issues requests and configuration, observes status
    modport master (
        output req, prog_sel, cfg_we, cfg_idx, cfg_addr, abort, halt,
        input  core_reset, pc_load, pc_load_val, run, busy, ack, timeout, aborted, cycles
    );

    // Launcher side
    modport slave (
        input  req, prog_sel, cfg_we, cfg_idx, cfg_addr, abort, halt,
        output core_reset, pc_load, pc_load_val, run, busy, ack, timeout, aborted, cycles
    );
endinterface

// File: rtl/prog_launcher.sv
// Program launcher: on a rising edge of req, resets the core, loads its PC from
// a small start-address table, lets it run until halt, abort or timeout, and
// then holds ack until the next launch.
module prog_launcher #(
    parameter int NUM_PROGS  = 4,
    parameter int PC_W       = 10,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000,
    parameter int STRIDE     = 64
) (
    input  logic           clk,
    input  logic           reset,
    prog_launcher_if.slave bus
);
    localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic             req_q;
    logic             trigger;
    logic [PC_W-1:0]  prog_table [NUM_PROGS];
    logic [PC_W-1:0]  sel_addr;
    logic [CNT_W-1:0] cycles_next;
    logic             timeout_hit;

    assign trigger = bus.req & ~req_q;

    // Table lookup for the requested program; out-of-range selects fall back to entry 0
    always_comb begin
        sel_addr = prog_table[0];
        for (int i = 1; i < NUM_PROGS; i++) begin
            if (bus.prog_sel == SEL_W'(i)) begin
                sel_addr = prog_table[i];
            end
        end
    end

    // Saturating run-cycle increment and the timeout condition on the new count
    always_comb begin
        cycles_next = (&bus.cycles) ? bus.cycles : bus.cycles + CNT_W'(1);
        timeout_hit = (MAX_CYCLES != 0) && (32'(cycles_next) == 32'(MAX_CYCLES));
    end

    // Start-address table: defaults on reset, host writes in any state, bad indices dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                prog_table[i] <= PC_W'(i * STRIDE);
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                if (bus.cfg_idx == SEL_W'(i)) begin
                    prog_table[i] <= bus.cfg_addr;
                end
            end
        end
    end

    // Launch sequencer; the start address is captured on the trigger edge so
    // table writes in the trigger or LOAD cycle do not affect this launch
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            req_q           <= 1'b0;
            bus.core_reset  <= 1'b1;
            bus.pc_load     <= 1'b0;
            bus.pc_load_val <= '0;
            bus.run         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.ack         <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.aborted     <= 1'b0;
            bus.cycles      <= '0;
        end else begin
            req_q <= bus.req;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (trigger) begin
                        state           <= ST_LOAD;
                        bus.core_reset  <= 1'b1;
                        bus.pc_load     <= 1'b1;
                        bus.pc_load_val <= sel_addr;
                        bus.busy        <= 1'b1;
                        bus.ack         <= 1'b0;
                        bus.timeout     <= 1'b0;
                        bus.aborted     <= 1'b0;
                        bus.cycles      <= '0;
                    end
                end
                ST_LOAD: begin
                    state          <= ST_RUN;
                    bus.core_reset <= 1'b0;
                    bus.pc_load    <= 1'b0;
                    bus.run        <= 1'b1;
                end
                ST_RUN: begin
                    bus.cycles <= cycles_next;
                    if (bus.halt || bus.abort || timeout_hit) begin
                        state       <= ST_DONE;
                        bus.run     <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.ack     <= 1'b1;
                        bus.aborted <= ~bus.halt & bus.abort;
                        bus.timeout <= ~bus.halt & ~bus.abort & timeout_hit;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_launcher.sv
// Testbench for prog_launcher: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_prog_launcher;
    localparam int NUM_PROGS  = 3;
    localparam int PC_W       = 10;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 8;
    localparam int STRIDE     = 64;
    localparam int SEL_W      = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef enum {P_IDLE, P_LOAD, P_RUN, P_DONE} phase_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prog_launcher_if #(.SEL_W(SEL_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    prog_launcher #(
        .NUM_PROGS (NUM_PROGS),
        .PC_W      (PC_W),
        .CNT_W     (CNT_W),
        .MAX_CYCLES(MAX_CYCLES),
        .STRIDE    (STRIDE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    phase_t mPhase;
    int     mTbl [NUM_PROGS];
    bit     mReqPrev;
    int     mLoadVal;
    int     mCycles;
    bit     mTimeout;
    bit     mAborted;
    bit     modelValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int sel);
        bus.req      = 1'b1;
        bus.prog_sel = SEL_W'(sel);
        tick();
        bus.req      = 1'b0;
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 3) == 0) bus.req = ~bus.req;
        bus.prog_sel = SEL_W'($urandom_range(0, 3));
        bus.halt     = ($urandom_range(0, 9) == 0);
        bus.abort    = ($urandom_range(0, 15) == 0);
        bus.cfg_we   = ($urandom_range(0, 7) == 0);
        bus.cfg_idx  = SEL_W'($urandom_range(0, 3));
        bus.cfg_addr = PC_W'($urandom_range(0, 1023));
        reset        = ($urandom_range(0, 299) == 0);
    endtask

    // Behavioural model: one launch transaction at a time, advanced on each clock edge
    always @(posedge clk) begin : model
        bit trig;
        int sel;
        if (reset) begin
            mPhase     = P_IDLE;
            mReqPrev   = 1'b0;
            mLoadVal   = 0;
            mCycles    = 0;
            mTimeout   = 1'b0;
            mAborted   = 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) mTbl[i] = (i * STRIDE) % (1 << PC_W);
            modelValid = 1'b1;
        end else if (modelValid) begin
            trig     = bus.req && !mReqPrev;
            mReqPrev = bus.req;
            case (mPhase)
                P_IDLE, P_DONE: begin
                    if (trig) begin
                        sel      = int'(bus.prog_sel);
                        mLoadVal = (sel < NUM_PROGS) ? mTbl[sel] : mTbl[0];
                        mCycles  = 0;
                        mTimeout = 1'b0;
                        mAborted = 1'b0;
                        mPhase   = P_LOAD;
                    end
                end
                P_LOAD: mPhase = P_RUN;
                P_RUN: begin
                    if (mCycles < CNT_MAX) mCycles = mCycles + 1;
                    if (bus.halt) begin
                        mPhase = P_DONE;
                    end else if (bus.abort) begin
                        mPhase   = P_DONE;
                        mAborted = 1'b1;
                    end else if (MAX_CYCLES != 0 && mCycles == MAX_CYCLES) begin
                        mPhase   = P_DONE;
                        mTimeout = 1'b1;
                    end
                end
            endcase
            if (bus.cfg_we && int'(bus.cfg_idx) < NUM_PROGS) mTbl[int'(bus.cfg_idx)] = int'(bus.cfg_addr);
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("core_reset",  32'(bus.core_reset),  32'(mPhase == P_IDLE || mPhase == P_LOAD));
            checkOutput("pc_load",     32'(bus.pc_load),     32'(mPhase == P_LOAD));
            checkOutput("pc_load_val", 32'(bus.pc_load_val), 32'(mLoadVal));
            checkOutput("run",         32'(bus.run),         32'(mPhase == P_RUN));
            checkOutput("busy",        32'(bus.busy),        32'(mPhase == P_LOAD || mPhase == P_RUN));
            checkOutput("ack",         32'(bus.ack),         32'(mPhase == P_DONE));
            checkOutput("timeout",     32'(bus.timeout),     32'(mTimeout));
            checkOutput("aborted",     32'(bus.aborted),     32'(mAborted));
            checkOutput("cycles",      32'(bus.cycles),      32'(mCycles));
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        bus.req = 1'b0; bus.prog_sel = '0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
        bus.cfg_addr = '0; bus.abort = 1'b0; bus.halt = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_core_reset", 32'(bus.core_reset), 32'd1);
        checkOutput("rst_ack",        32'(bus.ack),        32'd0);
        checkOutput("rst_busy",       32'(bus.busy),       32'd0);
        checkOutput("rst_cycles",     32'(bus.cycles),     32'd0);
        reset = 1'b0;

        $display("[TB] basic launch with halt");
        launch(0);
        checkOutput("t1_pc_load",     32'(bus.pc_load),     32'd1);
        checkOutput("t1_pc_load_val", 32'(bus.pc_load_val), 32'd0);
        tick();
        repeat (4) tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        checkOutput("t1_cycles",    32'(bus.cycles),  32'd5);
        checkOutput("t1_ack",       32'(bus.ack),     32'd1);
        checkOutput("t1_timeout",   32'(bus.timeout), 32'd0);
        checkOutput("model_cycles", 32'(mCycles),     32'd5);

        $display("[TB] table write and trigger-cycle write");
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_addr = 10'h155;
        tick();
        bus.cfg_we = 1'b0;
        launch(2);
        checkOutput("t2_pc_load",     32'(bus.pc_load),     32'd1);
        checkOutput("t2_pc_load_val", 32'(bus.pc_load_val), 32'h155);
        tick();
        checkOutput("t2_pc_load_pulse", 32'(bus.pc_load), 32'd0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_addr = 10'h2AA;
        launch(2);
        bus.cfg_we = 1'b0;
        checkOutput("t2_old_value", 32'(bus.pc_load_val), 32'h155);
        checkOutput("model_loadval", 32'(mLoadVal), 32'h155);
        tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_addr = 10'h0C3;
        tick();
        bus.cfg_idx = 2'd3; bus.cfg_addr = 10'h111;
        tick();
        bus.cfg_we = 1'b0;
        launch(3);
        checkOutput("t2_oor_sel", 32'(bus.pc_load_val), 32'h0C3);
        tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;

        $display("[TB] timeout");
        launch(1);
        checkOutput("t3_pc_load_val", 32'(bus.pc_load_val), 32'd64);
        tick();
        repeat (7) tick();
        checkOutput("t3_run_c8",    32'(bus.run),    32'd1);
        checkOutput("t3_cycles_c8", 32'(bus.cycles), 32'd7);
        tick();
        checkOutput("t3_ack",     32'(bus.ack),     32'd1);
        checkOutput("t3_timeout", 32'(bus.timeout), 32'd1);
        checkOutput("t3_cycles",  32'(bus.cycles),  32'd8);
        launch(1);
        tick();
        repeat (7) tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        checkOutput("t3_halt8_timeout", 32'(bus.timeout), 32'd0);
        checkOutput("t3_halt8_cycles",  32'(bus.cycles),  32'd8);

        $display("[TB] abort");
        launch(0);
        tick();
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("t4_aborted", 32'(bus.aborted), 32'd1);
        checkOutput("t4_cycles",  32'(bus.cycles),  32'd3);
        checkOutput("t4_ack",     32'(bus.ack),     32'd1);
        launch(0);
        tick();
        bus.abort = 1'b1; bus.halt = 1'b1;
        tick();
        bus.abort = 1'b0; bus.halt = 1'b0;
        checkOutput("t4_both_aborted", 32'(bus.aborted), 32'd0);
        checkOutput("t4_both_ack",     32'(bus.ack),     32'd1);

        $display("[TB] request edges");
        launch(0);
        tick();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        checkOutput("t5_run_kept",  32'(bus.run),     32'd1);
        checkOutput("t5_no_reload", 32'(bus.pc_load), 32'd0);
        bus.req = 1'b1; bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        tick();
        checkOutput("t5_held_ack",  32'(bus.ack),     32'd1);
        checkOutput("t5_held_load", 32'(bus.pc_load), 32'd0);
        bus.req = 1'b0;
        tick();
        launch(0);
        checkOutput("t5_relaunch_ack",  32'(bus.ack),     32'd0);
        checkOutput("t5_relaunch_load", 32'(bus.pc_load), 32'd1);
        tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;

        $display("[TB] reset mid-run");
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_addr = 10'h3FF;
        tick();
        bus.cfg_we = 1'b0;
        launch(0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_run",        32'(bus.run),        32'd0);
        checkOutput("t6_ack",        32'(bus.ack),        32'd0);
        checkOutput("t6_busy",       32'(bus.busy),       32'd0);
        checkOutput("t6_core_reset", 32'(bus.core_reset), 32'd1);
        launch(1);
        checkOutput("t6_table_default", 32'(bus.pc_load_val), 32'd64);
        tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus();
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
